// File: rtl/wb_pkg.sv
// Shared write-back definitions: source select codes, load formats
// and the registered write-back entry.
package wb_pkg;

    localparam int WB_XLEN    = 32;
    localparam int WB_RADDR_W = 5;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;
    localparam int WB_SRC_PC4 = 2;
    localparam int WB_SRC_IMM = 3;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    typedef struct packed {
        logic [WB_RADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    wdata;
        logic                  we;
        logic                  misalign;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment and extension; misaligned half/word loads
// return zero data and raise o_misalign.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        case (i_funct3)
            LD_B:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LD_BU: o_data = XLEN'(w_byte);
            LD_H: begin
                if (i_addr_lo[0]) o_misalign = 1'b1;
                else o_data = {{(XLEN-16){w_half[15]}}, w_half};
            end
            LD_HU: begin
                if (i_addr_lo[0]) o_misalign = 1'b1;
                else o_data = XLEN'(w_half);
            end
            // LW and any unlisted format load the full word
            default: begin
                if (i_addr_lo != 2'b00) o_misalign = 1'b1;
                else o_data = i_word;
            end
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Write-back stage: source select, load alignment, write qualification
// and a main+skid register pair between MEM and the register file.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int XLEN     = WB_XLEN,
    parameter int NSRC     = 4,
    parameter int MEM_IDX  = WB_SRC_MEM,
    parameter int RADDR_W  = WB_RADDR_W,
    localparam int SEL_W   = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic [RADDR_W-1:0]   in_rd,
    input  logic                 in_rd_we,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RADDR_W-1:0]   out_rd,
    output logic [XLEN-1:0]      out_wdata,
    output logic                 out_we,
    output logic                 out_misalign,
    output logic [31:0]          retire_count
);

    localparam logic [SEL_W:0] NSRC_L = (SEL_W+1)'(NSRC);

    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_ld_data;
    logic            w_ld_mis;
    logic            w_sel_ok;
    logic            w_is_mem;
    logic            w_accept;
    logic            w_drain;
    logic            w_main_free;
    wb_entry_t       w_new;

    wb_entry_t       r_main;
    wb_entry_t       r_skid;
    logic            r_main_v;
    logic            r_skid_v;
    logic [31:0]     r_count;

    assign w_sel_ok = {1'b0, in_sel} < NSRC_L;
    assign w_is_mem = in_sel == SEL_W'(MEM_IDX);
    assign w_src    = in_src[in_sel*XLEN +: XLEN];

    wb_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_word     (in_src[MEM_IDX*XLEN +: XLEN]),
        .i_funct3   (in_funct3),
        .i_addr_lo  (in_addr_lo),
        .o_data     (w_ld_data),
        .o_misalign (w_ld_mis)
    );

    // Out-of-range selects yield a zero, non-writing, non-misaligned entry
    always_comb begin
        w_new    = '0;
        w_new.rd = in_rd;
        if (w_sel_ok) begin
            w_new.misalign = w_is_mem && w_ld_mis;
            w_new.wdata    = w_is_mem ? w_ld_data : w_src;
        end
        w_new.we = in_rd_we && (in_rd != '0) && w_sel_ok && !w_new.misalign;
    end

    assign in_ready    = !r_skid_v;
    assign w_accept    = in_valid && !r_skid_v;
    assign w_drain     = r_main_v && out_ready;
    assign w_main_free = !r_main_v || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main   <= '0;
            r_skid   <= '0;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_drain && r_main.we) r_count <= r_count + 32'd1;
            if (flush) begin
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (w_main_free) begin
                if (r_skid_v) begin
                    r_main   <= r_skid;
                    r_main_v <= 1'b1;
                    r_skid_v <= 1'b0;
                end else if (w_accept) begin
                    r_main   <= w_new;
                    r_main_v <= 1'b1;
                end else begin
                    r_main_v <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid   <= w_new;
                r_skid_v <= 1'b1;
            end
        end
    end

    assign out_valid    = r_main_v;
    assign out_rd       = r_main.rd;
    assign out_wdata    = r_main.wdata;
    assign out_we       = r_main_v && r_main.we;
    assign out_misalign = r_main_v && r_main.misalign;
    assign retire_count = r_count;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios plus a randomized
// stream checked against a queue-based reference.
module tb_wb_select_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] src;
    logic [1:0]   sel;
    logic [2:0]   f3;
    logic [1:0]   lo;
    logic [4:0]   rd;
    logic         rd_we;

    logic         in_ready, out_valid, out_we, out_misalign;
    logic [4:0]   out_rd;
    logic [31:0]  out_wdata, retire_count;

    logic         in_ready3, out_valid3, out_we3, out_mis3;
    logic [4:0]   out_rd3;
    logic [31:0]  out_wdata3, count3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_select_stage #(.NSRC(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src(src), .in_sel(sel), .in_funct3(f3),
        .in_addr_lo(lo), .in_rd(rd), .in_rd_we(rd_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_wdata(out_wdata), .out_we(out_we),
        .out_misalign(out_misalign), .retire_count(retire_count)
    );

    wb_select_stage #(.NSRC(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_src(src[95:0]), .in_sel(sel), .in_funct3(f3),
        .in_addr_lo(lo), .in_rd(rd), .in_rd_we(rd_we),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_rd(out_rd3), .out_wdata(out_wdata3), .out_we(out_we3),
        .out_misalign(out_mis3), .retire_count(count3)
    );

    // Expected entry {rd, wdata, we, misalign} from the load/select rules
    function automatic logic [38:0] ref_entry(input logic [127:0] s, input int sl,
        input int ns, input logic [2:0] f, input logic [1:0] l,
        input logic [4:0] r, input logic rw);
        logic [31:0] w, b, h, d;
        logic mis, we;
        w   = s[63:32];
        b   = (w >> (8 * l)) & 32'hFF;
        h   = (w >> (16 * l[1])) & 32'hFFFF;
        mis = 1'b0;
        d   = 32'h0;
        if (sl >= ns) d = 32'h0;
        else if (sl != 1) d = s[sl*32 +: 32];
        else begin
            case (f)
                3'd0: d = (b >= 128) ? b - 256 : b;
                3'd4: d = b;
                3'd1: begin mis = l[0]; d = (h >= 32768) ? h - 65536 : h; end
                3'd5: begin mis = l[0]; d = h; end
                default: begin mis = (l != 2'd0); d = w; end
            endcase
            if (mis) d = 32'h0;
        end
        we = rw && (r != 5'd0) && (sl < ns) && !mis;
        return {r, d, we, mis};
    endfunction

    task automatic put(input logic [1:0] s, input logic [31:0] data,
        input logic [2:0] f, input logic [1:0] l, input logic [4:0] r,
        input logic w);
        src = {$urandom, $urandom, $urandom, $urandom};
        src[s*32 +: 32] = data;
        sel = s; f3 = f; lo = l; rd = r; rd_we = w;
        in_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b1;
        put(0, 32'h1111_0001, 0, 0, 5'd1, 1'b1);
        @(posedge clk); @(negedge clk);
        put(0, 32'h2222_0002, 0, 0, 5'd2, 1'b1);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        put(0, 32'h3333_0003, 0, 0, 5'd3, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (retire_count !== 32'd1) begin n_fail++; $display("FAIL pre_rst_count got=%0d want=1", retire_count); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pre_rst_ready got=%0b want=0", in_ready); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0b want=1", in_ready); end
        n_tests++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL rst_count got=%0d want=0", retire_count); end
        n_tests++; if (out_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%0b want=0", out_we); end
        n_tests++; if (out_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_mis got=%0b want=0", out_misalign); end
        n_tests++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got=%0d want=0", out_rd); end
        n_tests++; if (out_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got=%h want=0", out_wdata); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got=%0b want=0", out_valid); end
    endtask

    task automatic test_alu();
        do_reset();
        out_ready = 1'b1;
        put(0, 32'h1234_5678, 0, 0, 5'd5, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid got=%0b want=1", out_valid); end
        n_tests++; if (out_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_wdata got=%h want=12345678", out_wdata); end
        n_tests++; if (out_we !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%0b want=1", out_we); end
        n_tests++; if (out_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got=%0d want=5", out_rd); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (retire_count !== 32'd1) begin n_fail++; $display("FAIL alu_count got=%0d want=1", retire_count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drained got=%0b want=0", out_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [8] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1, 3'd3, 3'd6};
        logic [1:0]  los [8] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
        logic [31:0] wds [8] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                                 32'h0, 32'h0, 32'h80FF_7F01, 32'h0};
        logic        wes [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(1, 32'h80FF_7F01, f3s[i], los[i], 5'd9, 1'b1);
            @(posedge clk); @(negedge clk);
            n_tests++; if (out_wdata !== wds[i]) begin n_fail++; $display("FAIL load%0d_wdata got=%h want=%h", i, out_wdata, wds[i]); end
            n_tests++; if (out_we !== wes[i]) begin n_fail++; $display("FAIL load%0d_we got=%0b want=%0b", i, out_we, wes[i]); end
            n_tests++; if (out_misalign !== !wes[i]) begin n_fail++; $display("FAIL load%0d_mis got=%0b want=%0b", i, out_misalign, !wes[i]); end
        end
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++; if (retire_count !== 32'd5) begin n_fail++; $display("FAIL load_count got=%0d want=5", retire_count); end
    endtask

    task automatic test_x0_badsel();
        do_reset();
        out_ready = 1'b1;
        put(0, 32'hDEAD_BEEF, 0, 0, 5'd0, 1'b1);
        @(posedge clk); @(negedge clk);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL x0_valid got=%0b want=1", out_valid); end
        n_tests++; if (out_we !== 1'b0) begin n_fail++; $display("FAIL x0_we got=%0b want=0", out_we); end
        n_tests++; if (out_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL x0_wdata got=%h want=deadbeef", out_wdata); end
        put(3, 32'hCAFE_F00D, 0, 0, 5'd4, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL imm_wdata got=%h want=cafef00d", out_wdata); end
        n_tests++; if (out_we !== 1'b1) begin n_fail++; $display("FAIL imm_we got=%0b want=1", out_we); end
        n_tests++; if (out_valid3 !== 1'b1) begin n_fail++; $display("FAIL bad_valid got=%0b want=1", out_valid3); end
        n_tests++; if (out_we3 !== 1'b0) begin n_fail++; $display("FAIL bad_we got=%0b want=0", out_we3); end
        n_tests++; if (out_wdata3 !== 32'h0) begin n_fail++; $display("FAIL bad_wdata got=%h want=0", out_wdata3); end
        n_tests++; if (out_mis3 !== 1'b0) begin n_fail++; $display("FAIL bad_mis got=%0b want=0", out_mis3); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (retire_count !== 32'd1) begin n_fail++; $display("FAIL x0_count got=%0d want=1", retire_count); end
        n_tests++; if (count3 !== 32'd0) begin n_fail++; $display("FAIL bad_count got=%0d want=0", count3); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        logic [31:0] got [$];
        logic acc;
        do_reset();
        out_ready = 1'b0;
        put(0, exp[0], 0, 0, 5'd10, 1'b1);
        @(posedge clk); @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got=%0b want=1", in_ready); end
        put(0, exp[1], 0, 0, 5'd11, 1'b1);
        @(posedge clk); @(negedge clk);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got=%0b want=0", in_ready); end
        put(0, exp[2], 0, 0, 5'd12, 1'b1);
        @(posedge clk); @(negedge clk);
        n_tests++; if (out_wdata !== exp[0]) begin n_fail++; $display("FAIL bp_hold got=%h want=%h", out_wdata, exp[0]); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready3 got=%0b want=0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_wdata);
            @(posedge clk); @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_nout got=%0d want=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_fail++; $display("FAIL bp_order%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 32'hX, exp[i]);
            end
        end
        n_tests++; if (retire_count !== 32'd3) begin n_fail++; $display("FAIL bp_count got=%0d want=3", retire_count); end
    endtask

    task automatic test_random();
        logic [38:0] q [$];
        logic [38:0] e;
        logic [31:0] cnt;
        logic acc, drn;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, out_valid, q.size() > 0); end
            n_tests++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", i, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                n_tests++;
                if ({out_rd, out_wdata, out_we, out_misalign} !== q[0]) begin
                    n_fail++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, {out_rd, out_wdata, out_we, out_misalign}, q[0]);
                end
            end
            n_tests++; if (retire_count !== cnt) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, retire_count, cnt); end
            src = {$urandom, $urandom, $urandom, $urandom};
            sel = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            lo = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd_we = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            e = ref_entry(src, int'(sel), 4, f3, lo, rd, rd_we);
            @(posedge clk);
            if (drn) begin
                if (q[0][1]) cnt = cnt + 1;
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_flush_wrap();
        do_reset();
        out_ready = 1'b0;
        put(0, 32'h0BAD_F00D, 0, 0, 5'd3, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        force dut.r_count = 32'hFFFF_FFFF;
        #1 release dut.r_count;
        n_tests++; if (retire_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fl_preload got=%h want=ffffffff", retire_count); end
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        put(0, 32'h5555_AAAA, 0, 0, 5'd6, 1'b1);
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL fl_wrap got=%h want=0", retire_count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%0b want=0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got=%0b want=1", in_ready); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_discard got=%0b want=0", out_valid); end
        n_tests++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL fl_count got=%h want=0", retire_count); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src = '0; sel = '0; f3 = '0; lo = '0; rd = '0; rd_we = 1'b0;
        test_reset();
        test_alu();
        test_loads();
        test_x0_badsel();
        test_backpressure();
        test_random();
        test_flush_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
